// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: MdOp codes, FSM states, iteration count.
package muldiv_pkg;

  localparam int unsigned MD_ITER = 32;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // Magnitude of a 32-bit operand; unsigned ops pass through untouched.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Iterative shift-add multiplier / restoring divider on unsigned magnitudes, with its bit counter.
// Result sits in {o_hi, o_lo}: product, or remainder/quotient.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ld_mul,
  input  logic                  i_ld_div,
  input  logic                  i_ld_raw,
  input  logic                  i_step_mul,
  input  logic                  i_step_div,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  input  logic [2*DATA_W-1:0]   i_raw,
  output logic [DATA_W-1:0]     o_hi,
  output logic [DATA_W-1:0]     o_lo,
  output logic                  o_last_c
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_b;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W:0]   w_mul_sum;
  logic [DATA_W:0]   w_rem_sh;
  logic [DATA_W-1:0] w_trial;
  logic              w_ge;

  // Multiply: conditionally add multiplicand into the upper half, then shift the pair right.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

  // Divide: shift remainder left pulling in the next dividend bit, subtract if it fits.
  assign w_rem_sh = {r_hi, r_lo[DATA_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_b});
  assign w_trial  = w_rem_sh[DATA_W-1:0] - r_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (i_ld_mul) begin
      r_hi  <= '0;
      r_lo  <= i_b;
      r_b   <= i_a;
      r_cnt <= CNT_W'(MD_ITER - 1);
    end else if (i_ld_div) begin
      r_hi  <= '0;
      r_lo  <= i_a;
      r_b   <= i_b;
      r_cnt <= CNT_W'(MD_ITER - 1);
    end else if (i_ld_raw) begin
      {r_hi, r_lo} <= i_raw;
    end else if (i_step_mul) begin
      {r_hi, r_lo} <= {w_mul_sum, r_lo[DATA_W-1:1]};
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end else if (i_step_div) begin
      r_hi <= w_ge ? w_trial : w_rem_sh[DATA_W-1:0];
      r_lo <= {r_lo[DATA_W-2:0], w_ge};
      if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_hi     = r_hi;
  assign o_lo     = r_lo;
  assign o_last_c = (r_cnt == '0);

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multicycle MULT/DIV unit with architectural HI/LO and MTHI/MTLO writes.
// Define MULDIV_FAST_MUL_EN for a single-cycle '*' multiply; divide stays iterative.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        MdOp,
  input  logic [DATA_W-1:0] OpA,
  input  logic [DATA_W-1:0] OpB,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  state_e            r_state;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic              r_neg_lo;
  logic              r_neg_hi;
  logic              r_is_div;

  logic              w_is_mul;
  logic              w_is_div;
  logic              w_signed;
  logic              w_issue;
  logic              w_div0;
  logic [DATA_W-1:0] w_mag_a;
  logic [DATA_W-1:0] w_mag_b;
  logic              w_ld_mul;
  logic              w_ld_div;
  logic              w_ld_raw;
  logic [PROD_W-1:0] w_raw;
  logic [PROD_W-1:0] w_prod_fast;
  logic [DATA_W-1:0] w_core_hi;
  logic [DATA_W-1:0] w_core_lo;
  logic              w_last;
  logic [PROD_W-1:0] w_prod;
  logic [PROD_W-1:0] w_prod_fix;
  logic [DATA_W-1:0] w_quo_fix;
  logic [DATA_W-1:0] w_rem_fix;

`ifdef MULDIV_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
  assign w_prod_fast = PROD_W'(w_mag_a) * PROD_W'(w_mag_b);
`else
  localparam logic FAST_MUL = 1'b0;
  assign w_prod_fast = '0;
`endif

  assign w_is_mul = (MdOp == MD_MULT) || (MdOp == MD_MULTU);
  assign w_is_div = (MdOp == MD_DIV)  || (MdOp == MD_DIVU);
  assign w_signed = (MdOp == MD_MULT) || (MdOp == MD_DIV);
  assign w_issue  = (r_state == ST_IDLE) && Start;
  assign w_div0   = (OpB == '0);
  assign w_mag_a  = mag32(OpA, w_signed);
  assign w_mag_b  = mag32(OpB, w_signed);

  // Divide-by-zero and fast multiply bypass iteration by loading the core result directly.
  assign w_ld_mul = w_issue && w_is_mul && !FAST_MUL;
  assign w_ld_div = w_issue && w_is_div && !w_div0;
  assign w_ld_raw = w_issue && ((w_is_div && w_div0) || (w_is_mul && FAST_MUL));
  assign w_raw    = w_is_mul ? w_prod_fast : {OpA, {DATA_W{1'b1}}};

  muldiv_iter_core #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_core (
    .i_clk      (Clk),
    .i_rst      (Reset),
    .i_ld_mul   (w_ld_mul),
    .i_ld_div   (w_ld_div),
    .i_ld_raw   (w_ld_raw),
    .i_step_mul (r_state == ST_MUL),
    .i_step_div (r_state == ST_DIV),
    .i_a        (w_mag_a),
    .i_b        (w_mag_b),
    .i_raw      (w_raw),
    .o_hi       (w_core_hi),
    .o_lo       (w_core_lo),
    .o_last_c   (w_last)
  );

  // Sign fix-up of the magnitude result.
  assign w_prod     = {w_core_hi, w_core_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_lo ? -w_core_lo : w_core_lo;
  assign w_rem_fix  = r_neg_hi ? -w_core_hi : w_core_hi;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            if (MdOp == MD_MTHI) begin
              r_hi <= OpA;
            end else if (MdOp == MD_MTLO) begin
              r_lo <= OpA;
            end else if (w_is_mul) begin
              r_neg_lo <= w_signed & (OpA[DATA_W-1] ^ OpB[DATA_W-1]);
              r_neg_hi <= 1'b0;
              r_is_div <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= FAST_MUL ? ST_FIX : ST_MUL;
            end else if (w_is_div) begin
              r_is_div <= 1'b1;
              r_busy   <= 1'b1;
              if (w_div0) begin
                r_neg_lo <= 1'b0;
                r_neg_hi <= 1'b0;
                r_state  <= ST_FIX;
              end else begin
                r_neg_lo <= w_signed & (OpA[DATA_W-1] ^ OpB[DATA_W-1]);
                r_neg_hi <= w_signed & OpA[DATA_W-1];
                r_state  <= ST_DIV;
              end
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (w_last) r_state <= ST_FIX;
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end else begin
            {r_hi, r_lo} <= w_prod_fix;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
